kl_ram_responder: RTL and testbench
===================================

Name: kl_ram_responder

Overview:
- Simulation-side KL bus responder: accepts the bus requests emitted by the ML-to-KL request path and answers them from a behavioural 64-bit-wide RAM.
- Services read and write bursts with configurable response latency.
- Drives a valid/ready response channel back to the bridge.
- It is the terminating responder of the KL bus in the simulation top.

Parameters:
- BASE_ADDR, 32'h80000000, byte address mapped to RAM word 0
- DEPTH, 65536, RAM depth in 64-bit words (power of two)
- LATENCY, 2, cycles from request acceptance to first response beat (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_addr  input  32  byte address of first beat (8-byte aligned; bits [2:0] ignored)
- req_wen  input  1  1 = write, 0 = read
- req_wdata  input  64  write data, one beat
- req_wmask  input  8  byte enables for write beat
- req_size  input  3  burst length = 1<<req_size beats; legal values 0..3
- req_srcid  input  5  requester ID
- req_valid  input  1  request beat valid
- req_ready  output  1  request beat accepted when valid&&ready
- resp_rdata  output  64  read data
- resp_ren  output  1  1 = read data beat, 0 = write acknowledge
- resp_size  output  3  echo of request size
- resp_dstid  output  5  echo of req_srcid
- resp_valid  output  1  response beat valid
- resp_ready  input  1  response beat consumed when valid&&ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: req_ready=0, resp_valid=0, resp_ren=0, resp_rdata=0, resp_size=0, resp_dstid=0. FSM returns to IDLE. RAM contents are not cleared.
- Address mapping: word index = ((addr - BASE_ADDR) >> 3) mod DEPTH. Burst beats increment the index by 1 and wrap at DEPTH.
- Out-of-range accesses (addr < BASE_ADDR or offset >= DEPTH*8):
  - Reads return 64'hDEADBEEF_DEADBEEF.
  - Writes are dropped.
  - Response handshakes are otherwise identical to in-range accesses.
- FSM states: IDLE, WR_BURST, WAIT, RD_RESP, WR_ACK.
- IDLE: req_ready=1.
  - On a write handshake: latch addr/size/srcid, write beat 0 with wmask, set beat counter to 1. Go to WR_BURST, or to WAIT if size==0.
  - On a read handshake: latch fields, go to WAIT.
- WR_BURST: req_ready=1.
  - Each handshake writes the next beat at base+counter.
  - addr/size/srcid/wen of beats 1..N-1 are ignored.
  - After beat N-1 is written, go to WAIT.
- WAIT: req_ready=0. Counts LATENCY-1 cycles, then moves to RD_RESP (read) or WR_ACK (write). LATENCY=1 means the first response beat is valid the cycle after the last request beat is accepted.
- RD_RESP: resp_valid=1, resp_ren=1, resp_rdata=RAM[base+beat], resp_size and resp_dstid from latched fields.
  - Beat advances only on resp handshake. Data is held stable while resp_ready=0.
  - After beat N-1 is consumed, go to IDLE with resp_valid=0 the following cycle.
- WR_ACK: single beat with resp_valid=1, resp_ren=0, resp_rdata=0. On handshake, go to IDLE.
- Ordering: one transaction at a time, no request accepted while a response is pending. Read-after-write to the same address returns the new data.
- Write mask: only bytes with wmask[i]=1 are updated; wmask=0 leaves the word unchanged.
- Illegal req_size (4..7) is treated as size 3. resp_size still echoes the raw value.
- Reset mid-operation: any state returns to IDLE. Beats already written remain in RAM; no response is issued for the aborted transaction.
- Back-to-back transactions: a new request may be accepted in the cycle after the final response handshake. There is no IDLE bubble beyond that single cycle.

Test Plan:
- Single write then read:
  - Stimulus: write addr=0x80000010, size=0, wdata=0x1122334455667788, wmask=0xFF, srcid=3; then read same addr, srcid=5.
  - Response: write ack with ren=0, dstid=3; read beat with rdata=0x1122334455667788, ren=1, dstid=5, size=0.
- Partial mask:
  - Stimulus: write 0xFFFFFFFFFFFFFFFF to 0x80000020 with mask 0xFF, then write 0 with mask 0x0F, then read.
  - Response: rdata=0xFFFFFFFF00000000.
- Burst read with backpressure:
  - Stimulus: write 8 beats (size=3) at 0x80000100 with data 0..7; then read size=3 while resp_ready toggles 1,0,0,1...
  - Response: beats 0..7 in order, each held stable while stalled; exactly 8 read handshakes, then a single write ack earlier.
- Latency check (LATENCY=4):
  - Stimulus: read handshake at cycle t.
  - Response: resp_valid first high at t+4; req_ready=0 from t+1 until the response completes.
- Wrap and out-of-range:
  - Stimulus: with DEPTH=16, burst write size=2 starting at word 14.
  - Response: data lands in words 14, 15, 0, 1.
  - Stimulus: read 0x7FFFFFF8.
  - Response: 0xDEADBEEFDEADBEEF.
- Reset mid-burst:
  - Stimulus: assert rst after beat 1 of a 4-beat write.
  - Response: next cycle resp_valid=0, req_ready=0 during reset, then 1; reading back shows beats 0..1 written and beats 2..3 unchanged.

Source files
------------

// File: rtl/kl_ram_responder.sv
// KL bus terminating responder: services read/write bursts from a 64-bit behavioural RAM
// and returns one response beat per read word, or a single acknowledge per write burst.
module kl_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 65536,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic [2:0]  req_size,
  input  logic [4:0]  req_srcid,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_ren,
  output logic [2:0]  resp_size,
  output logic [4:0]  resp_dstid,
  output logic        resp_valid,
  input  logic        resp_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [63:0]   OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [2:0] {IDLE, WR_BURST, WAIT, RD_RESP, WR_ACK} state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, resp_valid_q, resp_ren_q;
  logic [2:0]      resp_size_q;
  logic [4:0]      resp_dstid_q;
  logic            wen_q, oor_q;
  logic [AW-1:0]   base_q;
  logic [2:0]      beat_q, last_q;
  logic [LW-1:0]   lat_q;

  logic [63:0]     ram [DEPTH];
  logic [63:0]     rd_data_q;

  logic            req_hs, resp_hs, req_oor;
  logic [31:0]     req_off;
  logic [AW-1:0]   req_idx;
  logic [2:0]      req_last;
  logic            wr_en, rd_en;
  logic [AW-1:0]   wr_idx, rd_idx;

  // Sizes above 3 behave as 8-beat bursts; only the echoed size keeps the raw value.
  function automatic logic [2:0] last_beat(input logic [2:0] size);
    case (size)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic state_t after_req(input logic wen);
    if (LATENCY == 1) return wen ? WR_ACK : RD_RESP;
    return WAIT;
  endfunction

  assign req_hs   = req_valid && req_ready_q;
  assign resp_hs  = resp_valid_q && resp_ready;
  assign req_off  = req_addr - BASE_ADDR;
  assign req_oor  = (req_addr < BASE_ADDR) || ({1'b0, req_off} >= (33'(DEPTH) << 3));
  assign req_idx  = req_off[AW+2:3];
  assign req_last = last_beat(req_size);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_hs) state_d = (req_wen && req_last != 3'd0) ? WR_BURST : after_req(req_wen);
      WR_BURST: if (req_hs && beat_q == last_q) state_d = after_req(wen_q);
      WAIT:     if (lat_q == LAT_LAST) state_d = wen_q ? WR_ACK : RD_RESP;
      RD_RESP:  if (resp_hs && beat_q == last_q) state_d = IDLE;
      WR_ACK:   if (resp_hs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The RAM read is issued one cycle ahead so the registered word is ready when each beat is presented.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = req_idx;
    rd_en  = 1'b0;
    rd_idx = base_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          wr_en  = req_hs && req_wen && !req_oor;
          rd_en  = req_hs && !req_wen && (LATENCY == 1);
          rd_idx = req_idx;
        end
        WR_BURST: begin
          wr_en  = req_hs && !oor_q;
          wr_idx = base_q + AW'(beat_q);
        end
        WAIT:    rd_en = (state_d == RD_RESP);
        RD_RESP: begin
          rd_en  = resp_hs && (beat_q != last_q);
          rd_idx = base_q + AW'(beat_q + 3'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wmask[b]) ram[wr_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
    if (rd_en) rd_data_q <= ram[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ren_q   <= 1'b0;
      resp_size_q  <= 3'd0;
      resp_dstid_q <= 5'd0;
      wen_q        <= 1'b0;
      oor_q        <= 1'b0;
      base_q       <= '0;
      beat_q       <= 3'd0;
      last_q       <= 3'd0;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == IDLE) || (state_d == WR_BURST);
      resp_valid_q <= (state_d == RD_RESP) || (state_d == WR_ACK);
      resp_ren_q   <= (state_d == RD_RESP);
      case (state_q)
        IDLE: if (req_hs) begin
          base_q       <= req_idx;
          last_q       <= req_last;
          resp_size_q  <= req_size;
          resp_dstid_q <= req_srcid;
          wen_q        <= req_wen;
          oor_q        <= req_oor;
          beat_q       <= req_wen ? 3'd1 : 3'd0;
          lat_q        <= '0;
        end
        WR_BURST: if (req_hs) beat_q <= beat_q + 3'd1;
        WAIT:     lat_q <= lat_q + 1'b1;
        RD_RESP:  if (resp_hs) beat_q <= beat_q + 3'd1;
        default: ;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_ren   = resp_ren_q;
  assign resp_size  = resp_size_q;
  assign resp_dstid = resp_dstid_q;
  assign resp_rdata = !resp_ren_q ? 64'd0 : (oor_q ? OOR_DATA : rd_data_q);

endmodule

// File: tb/tb_kl_ram_responder.sv
// Directed bench for kl_ram_responder: one instance with LATENCY=1/DEPTH=1024 and one with
// LATENCY=4/DEPTH=16, sharing stimulus and selected by sel.
module tb_kl_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [2:0]  req_size;
  logic [4:0]  req_srcid;
  logic        req_valid;
  logic        resp_ready;
  logic        sel;

  logic        a_req_ready, a_resp_ren, a_resp_valid;
  logic [63:0] a_resp_rdata;
  logic [2:0]  a_resp_size;
  logic [4:0]  a_resp_dstid;
  logic        b_req_ready, b_resp_ren, b_resp_valid;
  logic [63:0] b_resp_rdata;
  logic [2:0]  b_resp_size;
  logic [4:0]  b_resp_dstid;

  logic        req_ready_m, resp_ren_m, resp_valid_m;
  logic [63:0] resp_rdata_m;
  logic [2:0]  resp_size_m;
  logic [4:0]  resp_dstid_m;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      hs_cyc = 0;
  int          exp_lat = 1;
  logic [63:0] wq[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kl_ram_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_size(req_size), .req_srcid(req_srcid),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready), .resp_rdata(a_resp_rdata),
    .resp_ren(a_resp_ren), .resp_size(a_resp_size), .resp_dstid(a_resp_dstid),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel));

  kl_ram_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_size(req_size), .req_srcid(req_srcid),
    .req_valid(req_valid && sel), .req_ready(b_req_ready), .resp_rdata(b_resp_rdata),
    .resp_ren(b_resp_ren), .resp_size(b_resp_size), .resp_dstid(b_resp_dstid),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel));

  assign req_ready_m  = sel ? b_req_ready  : a_req_ready;
  assign resp_ren_m   = sel ? b_resp_ren   : a_resp_ren;
  assign resp_valid_m = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata_m = sel ? b_resp_rdata : a_resp_rdata;
  assign resp_size_m  = sel ? b_resp_size  : a_resp_size;
  assign resp_dstid_m = sel ? b_resp_dstid : a_resp_dstid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the beat is accepted.
  task automatic req_beat(input logic [31:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] m, input logic [2:0] s, input logic [4:0] id);
    int n = 0;
    req_addr = a; req_wen = w; req_wdata = d; req_wmask = m; req_size = s; req_srcid = id;
    req_valid = 1'b1;
    while (!req_ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_timeout", 64'(n), 64'd0);
    @(negedge clk);
    hs_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                          input logic [7:0] m, input string tag);
    int n = 0;
    int lat;
    for (int i = 0; i < wq.size(); i++) req_beat((i == 0) ? a : 32'h0, 1'b1, wq[i], m, s, id);
    wq.delete();
    while (!resp_valid_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = int'(cyc - hs_cyc) + 1;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ren"}, 64'(resp_ren_m), 64'd0);
    chk({tag, "_rdata"}, resp_rdata_m, 64'd0);
    chk({tag, "_dstid"}, 64'(resp_dstid_m), 64'(id));
    chk({tag, "_size"}, 64'(resp_size_m), 64'(s));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_after"}, 64'(resp_valid_m), 64'd0);
    chk({tag, "_ready_after"}, 64'(req_ready_m), 64'd1);
  endtask

  // bp=1 drives resp_ready with the repeating pattern 1,0,0.
  task automatic do_read(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                         input bit bp, input string tag);
    int nexp = exp_q.size();
    int got = 0;
    int k = 0;
    bit first = 1'b1;
    bit rdy_seen = 1'b0;
    req_beat(a, 1'b0, 64'd0, 8'h00, s, id);
    while (got < nexp && k < 200) begin
      resp_ready = bp ? (k % 3 == 0) : 1'b1;
      if (req_ready_m) rdy_seen = 1'b1;
      if (resp_valid_m) begin
        if (first) begin
          chk({tag, "_lat"}, 64'(int'(cyc - hs_cyc) + 1), 64'(exp_lat));
          chk({tag, "_dstid"}, 64'(resp_dstid_m), 64'(id));
          chk({tag, "_size"}, 64'(resp_size_m), 64'(s));
          first = 1'b0;
        end
        chk({tag, "_beat", $sformatf("%0d", got)}, resp_rdata_m, exp_q[got]);
        chk({tag, "_ren"}, 64'(resp_ren_m), 64'd1);
        if (resp_ready) got++;
      end
      k++;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk({tag, "_beats"}, 64'(got), 64'(nexp));
    chk({tag, "_ready_busy"}, 64'(rdy_seen), 64'd0);
    chk({tag, "_valid_after"}, 64'(resp_valid_m), 64'd0);
    chk({tag, "_ready_after"}, 64'(req_ready_m), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_wen = 1'b0; req_wdata = 64'd0; req_wmask = 8'h00;
    req_size = 3'd0; req_srcid = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 64'(a_req_ready), 64'd0);
    chk("rst_a_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_a_ren", 64'(a_resp_ren), 64'd0);
    chk("rst_a_rdata", a_resp_rdata, 64'd0);
    chk("rst_a_size", 64'(a_resp_size), 64'd0);
    chk("rst_a_dstid", 64'(a_resp_dstid), 64'd0);
    chk("rst_b_ready", 64'(b_req_ready), 64'd0);
    chk("rst_b_valid", 64'(b_resp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Instance A: LATENCY=1, DEPTH=1024
    wq = {64'h1122_3344_5566_7788};
    do_write(32'h8000_0010, 3'd0, 5'd3, 8'hFF, "wr1");
    exp_q = {64'h1122_3344_5566_7788};
    do_read(32'h8000_0010, 3'd0, 5'd5, 1'b0, "rd1");

    wq = {64'hFFFF_FFFF_FFFF_FFFF};
    do_write(32'h8000_0020, 3'd0, 5'd1, 8'hFF, "pm_a");
    wq = {64'h0};
    do_write(32'h8000_0020, 3'd0, 5'd1, 8'h0F, "pm_b");
    wq = {64'h1234};
    do_write(32'h8000_0020, 3'd0, 5'd1, 8'h00, "pm_c");
    exp_q = {64'hFFFF_FFFF_0000_0000};
    do_read(32'h8000_0020, 3'd0, 5'd2, 1'b0, "pm_rd");

    for (int i = 0; i < 8; i++) wq.push_back(64'(i));
    do_write(32'h8000_0100, 3'd3, 5'd7, 8'hFF, "bw");
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i));
    do_read(32'h8000_0100, 3'd3, 5'd9, 1'b1, "brd");
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i));
    do_read(32'h8000_0100, 3'd7, 5'd10, 1'b0, "sz7");

    // Instance B: LATENCY=4, DEPTH=16
    sel = 1'b1; exp_lat = 4;
    @(negedge clk);
    wq = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
    do_write(32'h8000_0070, 3'd2, 5'd4, 8'hFF, "wrap_w");
    exp_q = {64'hA2, 64'hA3};
    do_read(32'h8000_0000, 3'd1, 5'd4, 1'b0, "wrap_lo");
    exp_q = {64'hA0, 64'hA1};
    do_read(32'h8000_0070, 3'd1, 5'd4, 1'b0, "wrap_hi");

    wq = {64'h55};
    do_write(32'h8000_0080, 3'd0, 5'd6, 8'hFF, "oor_w");
    exp_q = {64'hDEAD_BEEF_DEAD_BEEF};
    do_read(32'h8000_0080, 3'd0, 5'd6, 1'b0, "oor_hi");
    exp_q = {64'hDEAD_BEEF_DEAD_BEEF};
    do_read(32'h7FFF_FFF8, 3'd0, 5'd6, 1'b0, "oor_lo");
    exp_q = {64'hA2};
    do_read(32'h8000_0000, 3'd0, 5'd6, 1'b0, "oor_drop");

    wq = {64'hC0, 64'hC1, 64'hC2, 64'hC3};
    do_write(32'h8000_0020, 3'd2, 5'd8, 8'hFF, "pre");
    req_beat(32'h8000_0020, 1'b1, 64'hD0, 8'hFF, 3'd2, 5'd8);
    req_beat(32'h0, 1'b1, 64'hD1, 8'hFF, 3'd2, 5'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(resp_valid_m), 64'd0);
    chk("mid_rst_ready", 64'(req_ready_m), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!req_ready_m && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_ready", 64'(req_ready_m), 64'd1);
    chk("post_rst_valid", 64'(resp_valid_m), 64'd0);
    exp_q = {64'hD0, 64'hD1, 64'hC2, 64'hC3};
    do_read(32'h8000_0020, 3'd2, 5'd8, 1'b1, "rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
